txn_dispatcher: RTL and testbench

TXN_DISPATCHER -- requirements
Module: txn_dispatcher

---
 rtl/txn_pkg.sv | 38 +++
 rtl/txn_fifo.sv | 60 ++++++
 rtl/txn_dispatcher.sv | 196 +++++++++++++++++++
 tb/tb_txn_dispatcher.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txn_pkg.sv
// Shared encodings for the transaction dispatcher: request op codes, response
// status codes, controller states and the queued request record.
package txn_pkg;

  typedef enum logic [1:0] {
    OP_SEARCH   = 2'd0,
    OP_INSERT   = 2'd1,
    OP_TRANSACT = 2'd2,
    OP_ILLEGAL  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_NOT_FOUND    = 3'd1,
    ST_INSUFFICIENT = 3'd2,
    ST_OVERFLOW     = 3'd3,
    ST_TIMEOUT      = 3'd4,
    ST_BAD_OP       = 3'd5
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOOKUP,
    S_WAIT_LOOKUP,
    S_ISSUE,
    S_WAIT_OP,
    S_RESPOND
  } state_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] key;
    logic [31:0] value;
    logic        kind;
  } req_t;

endpackage

// File: rtl/txn_fifo.sv
// Synchronous request FIFO with registered occupancy count and a registered
// ready flag that depends only on the occupancy after the current cycle.
module txn_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && ready;
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: reset is synchronous and active-high, so it is sampled inside the
  // clocked block; all state updates use non-blocking assignments.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next != (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // decide which entries are valid, and this keeps the array a plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/txn_dispatcher.sv
// Pulls account requests from a queue, drives one key-value store operation
// at a time (with a balance pre-check for transacts) and returns a response.
module txn_dispatcher
  import txn_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_op,
  input  logic [31:0]                 req_key,
  input  logic [31:0]                 req_value,
  input  logic                        req_kind,
  output logic                        kv_start,
  output logic [1:0]                  kv_signal,
  output logic [31:0]                 kv_key,
  output logic [31:0]                 kv_value,
  output logic [31:0]                 kv_transact_value,
  output logic                        kv_transact_kind,
  input  logic                        kv_done,
  input  logic                        kv_found,
  input  logic [31:0]                 kv_value_addr,
  input  logic [31:0]                 kv_updated_value,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [2:0]                  rsp_status,
  output logic [31:0]                 rsp_value,
  output logic [31:0]                 rsp_addr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  state_e      state;
  req_t        push_entry;
  req_t        pop_entry;
  req_t        held;
  logic [TW-1:0] timer;
  logic [32:0] credit_sum;
  logic        fifo_pop;
  logic        timed_out;

  assign push_entry = '{op: op_e'(req_op), key: req_key, value: req_value, kind: req_kind};
  assign fifo_pop   = (state == S_POP);
  assign credit_sum = {1'b0, kv_updated_value} + {1'b0, held.value};
  // Timer counts cycles since kv_start; the last legal wait cycle is T-1.
  assign timed_out  = (timer >= TW'(TIMEOUT_CYCLES - 1));

  txn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_valid),
    .push_data (push_entry),
    .ready     (req_ready),
    .pop       (fifo_pop),
    .pop_data  (pop_entry),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      held              <= '0;
      timer             <= '0;
      kv_start          <= 1'b0;
      kv_signal         <= '0;
      kv_key            <= '0;
      kv_value          <= '0;
      kv_transact_value <= '0;
      kv_transact_kind  <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_status        <= '0;
      rsp_value         <= '0;
      rsp_addr          <= '0;
    end else begin
      kv_start <= 1'b0;
      case (state)
        S_IDLE: if (fifo_count != '0) state <= S_POP;

        S_POP: begin
          held              <= pop_entry;
          kv_key            <= pop_entry.key;
          kv_value          <= pop_entry.value;
          kv_transact_value <= pop_entry.value;
          kv_transact_kind  <= pop_entry.kind;
          timer             <= '0;
          case (pop_entry.op)
            OP_TRANSACT: begin
              kv_start  <= 1'b1;
              kv_signal <= OP_SEARCH;
              state     <= S_LOOKUP;
            end
            OP_ILLEGAL: begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_BAD_OP;
              rsp_value  <= '0;
              rsp_addr   <= '0;
              state      <= S_RESPOND;
            end
            default: begin
              kv_start  <= 1'b1;
              kv_signal <= pop_entry.op;
              state     <= S_ISSUE;
            end
          endcase
        end

        S_LOOKUP: begin
          timer <= timer + 1'b1;
          state <= S_WAIT_LOOKUP;
        end

        S_ISSUE: begin
          timer <= timer + 1'b1;
          state <= S_WAIT_OP;
        end

        S_WAIT_LOOKUP: begin
          timer <= timer + 1'b1;
          if (kv_done) begin
            rsp_value <= kv_updated_value;
            rsp_addr  <= kv_value_addr;
            if (!kv_found) begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_NOT_FOUND;
              rsp_value  <= '0;
              rsp_addr   <= '0;
              state      <= S_RESPOND;
            end else if (!held.kind && (held.value > kv_updated_value)) begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_INSUFFICIENT;
              state      <= S_RESPOND;
            end else if (held.kind && credit_sum[32]) begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_OVERFLOW;
              state      <= S_RESPOND;
            end else begin
              kv_start          <= 1'b1;
              kv_signal         <= OP_TRANSACT;
              kv_key            <= held.key;
              kv_transact_value <= held.value;
              kv_transact_kind  <= held.kind;
              timer             <= '0;
              state             <= S_ISSUE;
            end
          end else if (timed_out) begin
            rsp_valid  <= 1'b1;
            rsp_status <= ST_TIMEOUT;
            rsp_value  <= '0;
            rsp_addr   <= '0;
            state      <= S_RESPOND;
          end
        end

        S_WAIT_OP: begin
          timer <= timer + 1'b1;
          if (kv_done) begin
            rsp_valid <= 1'b1;
            state     <= S_RESPOND;
            if (held.op == OP_SEARCH && !kv_found) begin
              rsp_status <= ST_NOT_FOUND;
              rsp_value  <= '0;
              rsp_addr   <= '0;
            end else begin
              rsp_status <= ST_OK;
              rsp_value  <= kv_updated_value;
              rsp_addr   <= kv_value_addr;
            end
          end else if (timed_out) begin
            rsp_valid  <= 1'b1;
            rsp_status <= ST_TIMEOUT;
            rsp_value  <= '0;
            rsp_addr   <= '0;
            state      <= S_RESPOND;
          end
        end

        S_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_txn_dispatcher.sv
// Self-checking bench: a behavioural key-value store answers kv_start, and a
// reference account model predicts every response from the request stream.
module tb_txn_dispatcher;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  localparam logic [2:0] OK = 3'd0, NF = 3'd1, INS = 3'd2, OVF = 3'd3, TMO = 3'd4, BAD = 3'd5;

  logic        clock, reset;
  logic        req_valid, req_ready, req_kind;
  logic [1:0]  req_op;
  logic [31:0] req_key, req_value;
  logic        kv_start, kv_transact_kind, kv_done, kv_found;
  logic [1:0]  kv_signal;
  logic [31:0] kv_key, kv_value, kv_transact_value, kv_value_addr, kv_updated_value;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_status;
  logic [31:0] rsp_value, rsp_addr;
  logic [$clog2(DEPTH):0] fifo_count;

  txn_dispatcher #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .req_value(req_value), .req_kind(req_kind),
    .kv_start(kv_start), .kv_signal(kv_signal), .kv_key(kv_key), .kv_value(kv_value),
    .kv_transact_value(kv_transact_value), .kv_transact_kind(kv_transact_kind),
    .kv_done(kv_done), .kv_found(kv_found), .kv_value_addr(kv_value_addr),
    .kv_updated_value(kv_updated_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_value(rsp_value), .rsp_addr(rsp_addr), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [2:0]  status;
    logic [31:0] value;
    logic [31:0] addr;
    int          starts;
  } exp_t;

  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0, start_count = 0, last_starts = 0;
  exp_t exp_q[$];
  logic [31:0] rf_bal [logic [31:0]];
  logic [31:0] st_bal [logic [31:0]];

  // Store-model controls.
  logic stall = 0, withhold = 0, withhold_ops = 0, stray_done = 0;
  logic pending = 0;
  int   delay;
  logic [1:0]  cap_sig;
  logic [31:0] cap_key, cap_val, cap_tval;
  logic        cap_kind;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(logic [31:0] key);
    return 32'h8000_0000 | (key << 4);
  endfunction

  // Reference: account semantics computed directly from the request rules.
  function automatic exp_t model(logic [1:0] op, logic [31:0] key, logic [31:0] val, logic kind);
    exp_t e;
    e.status = NF; e.value = 0; e.addr = 0; e.starts = 1;
    case (op)
      2'd0: if (rf_bal.exists(key)) begin
        e.status = OK; e.value = rf_bal[key]; e.addr = addr_of(key);
      end
      2'd1: begin
        rf_bal[key] = val;
        e.status = OK; e.value = val; e.addr = addr_of(key);
      end
      2'd2: if (rf_bal.exists(key)) begin
        e.addr = addr_of(key);
        e.value = rf_bal[key];
        if (!kind && val > rf_bal[key]) e.status = INS;
        else if (kind && (64'(rf_bal[key]) + 64'(val) > 64'hFFFF_FFFF)) e.status = OVF;
        else begin
          rf_bal[key] = kind ? rf_bal[key] + val : rf_bal[key] - val;
          e.status = OK; e.value = rf_bal[key]; e.starts = 2;
        end
      end
      default: begin e.status = BAD; e.starts = 0; end
    endcase
    return e;
  endfunction

  // Behavioural key-value store responding to kv_start.
  initial begin
    kv_done = 0; kv_found = 0; kv_value_addr = 0; kv_updated_value = 0;
    forever begin
      @(negedge clock);
      kv_done = 0; kv_found = 0; kv_value_addr = 0; kv_updated_value = 0;
      if (reset) pending = 0;
      else if (stray_done) begin
        kv_done = 1; kv_found = 1; kv_updated_value = 32'hDEAD; stray_done = 0;
      end else if (kv_start) begin
        start_count++;
        start_cyc = cyc;
        if (!(withhold || (withhold_ops && kv_signal != 2'd0))) begin
          pending = 1; delay = $urandom_range(0, 3);
          cap_sig = kv_signal; cap_key = kv_key; cap_val = kv_value;
          cap_tval = kv_transact_value; cap_kind = kv_transact_kind;
        end
      end else if (pending) begin
        check("kv_hold", {kv_start, kv_signal, kv_key, kv_value, kv_transact_value, kv_transact_kind},
              {1'b0, cap_sig, cap_key, cap_val, cap_tval, cap_kind});
        if (!stall) begin
          if (delay != 0) delay--;
          else begin
            pending = 0; kv_done = 1;
            case (cap_sig)
              2'd0: if (st_bal.exists(cap_key)) begin
                kv_found = 1; kv_updated_value = st_bal[cap_key]; kv_value_addr = addr_of(cap_key);
              end
              2'd1: begin
                st_bal[cap_key] = cap_val;
                kv_found = 1; kv_updated_value = cap_val; kv_value_addr = addr_of(cap_key);
              end
              2'd2: if (st_bal.exists(cap_key)) begin
                st_bal[cap_key] = cap_kind ? st_bal[cap_key] + cap_tval : st_bal[cap_key] - cap_tval;
                kv_found = 1; kv_updated_value = st_bal[cap_key]; kv_value_addr = addr_of(cap_key);
              end
              default: kv_found = 0;
            endcase
          end
        end
      end
    end
  end

  task automatic push_raw(logic [1:0] op, logic [31:0] key, logic [31:0] val, logic kind);
    int w = 0;
    req_valid = 1; req_op = op; req_key = key; req_value = val; req_kind = kind;
    while (!req_ready && w < 2000) begin @(negedge clock); w++; end
    check("push_ready", req_ready, 1'b1);
    @(negedge clock);
  endtask

  task automatic push_req(logic [1:0] op, logic [31:0] key, logic [31:0] val, logic kind);
    exp_q.push_back(model(op, key, val, kind));
    push_raw(op, key, val, kind);
  endtask

  task automatic wait_rsp();
    int w = 0;
    while (!rsp_valid && w < 1000) begin @(negedge clock); w++; end
    check("rsp_wait", rsp_valid, 1'b1);
  endtask

  task automatic collect(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      wait_rsp();
      if (!rsp_valid || exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("rsp_status", rsp_status, e.status);
      check("rsp_value", rsp_value, e.value);
      check("rsp_addr", rsp_addr, e.addr);
      check("kv_starts", start_count - last_starts, e.starts);
      last_starts = start_count;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      check("rsp_held", {rsp_valid, rsp_status, rsp_value, rsp_addr}, {1'b1, e.status, e.value, e.addr});
      rsp_ready = 1;
      @(negedge clock);
      rsp_ready = 0;
    end
  endtask

  initial begin
    int seen;
    reset = 1; req_valid = 0; req_op = 0; req_key = 0; req_value = 0; req_kind = 0; rsp_ready = 0;
    repeat (3) @(negedge clock);
    check("rst_outputs", {req_ready, kv_start, rsp_valid, fifo_count, kv_signal, kv_key, rsp_status, rsp_value},
          {1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 3'd0, 32'd0});
    reset = 0;
    @(negedge clock);

    // Debit within balance, then debit beyond balance, then credit overflow.
    push_req(2'd1, 32'h11, 32'd100, 1'b0);
    push_req(2'd2, 32'h11, 32'd40, 1'b0);
    req_valid = 0; collect(2);
    push_req(2'd1, 32'h11, 32'd100, 1'b0);
    push_req(2'd2, 32'h11, 32'd200, 1'b0);
    req_valid = 0; collect(2);
    push_req(2'd1, 32'h22, 32'hFFFF_FFF8, 1'b0);
    push_req(2'd2, 32'h22, 32'h10, 1'b1);
    req_valid = 0; collect(2);
    // Exact-boundary credit and debit, unknown keys, illegal op, plain search.
    push_req(2'd1, 32'h33, 32'hFFFF_FFF0, 1'b0);
    push_req(2'd2, 32'h33, 32'hF, 1'b1);
    push_req(2'd2, 32'h33, 32'hFFFF_FFFF, 1'b0);
    push_req(2'd2, 32'h99, 32'd5, 1'b1);
    push_req(2'd0, 32'h99, 32'd0, 1'b0);
    push_req(2'd3, 32'h11, 32'd7, 1'b1);
    push_req(2'd0, 32'h11, 32'd0, 1'b0);
    req_valid = 0; collect(7);

    // Store stalled: first request in flight, eight more fill the queue.
    stall = 1;
    for (int i = 0; i < 9; i++) push_req(2'd1, 32'h40 + i, 32'(i * 10), 1'b0);
    req_valid = 0;
    check("full_count", fifo_count, 4'd8);
    check("full_ready", req_ready, 1'b0);
    repeat (3) @(negedge clock);
    check("full_hold", {req_ready, fifo_count}, {1'b0, 4'd8});
    stall = 0;
    collect(9);

    // Lookup never answered.
    withhold = 1;
    push_raw(2'd0, 32'h11, 32'd0, 1'b0);
    req_valid = 0;
    exp_q.push_back('{status: TMO, value: 32'd0, addr: 32'd0, starts: 1});
    wait_rsp();
    check("timeout_lookup_lat", cyc - start_cyc, TIMEOUT);
    collect(1);
    withhold = 0;

    // Lookup answered, transact write never answered.
    withhold_ops = 1;
    push_raw(2'd2, 32'h11, 32'd5, 1'b1);
    req_valid = 0;
    exp_q.push_back('{status: TMO, value: 32'd0, addr: 32'd0, starts: 2});
    wait_rsp();
    check("timeout_op_lat", cyc - start_cyc, TIMEOUT);
    collect(1);
    withhold_ops = 0;

    // Reset while waiting on a store write with more requests queued.
    withhold = 1;
    push_raw(2'd1, 32'h55, 32'd9, 1'b0);
    push_raw(2'd1, 32'h56, 32'd9, 1'b0);
    push_raw(2'd1, 32'h57, 32'd9, 1'b0);
    req_valid = 0;
    repeat (10) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("midop_reset", {req_ready, fifo_count, rsp_valid, kv_start}, {1'b1, 4'd0, 1'b0, 1'b0});
    withhold = 0;
    stray_done = 1;
    last_starts = start_count;
    seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (rsp_valid || kv_start) seen++;
    end
    check("midop_silent", seen, 0);
    push_req(2'd0, 32'h11, 32'd0, 1'b0);
    req_valid = 0; collect(1);

    // Randomised traffic against the reference model.
    for (int b = 0; b < 12; b++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        int r = $urandom_range(0, 9);
        logic [1:0]  op;
        logic [31:0] key, val;
        key = 32'h100 + $urandom_range(0, 7);
        val = ($urandom_range(0, 3) == 0) ? 32'hFFFF_0000 + $urandom_range(0, 65535) : $urandom_range(0, 1500);
        op  = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        push_req(op, key, val, 1'($urandom_range(0, 1)));
      end
      req_valid = 0;
      collect(n);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
